// File: rtl/xf100_ifu_fq_if.sv
// rtl/xf100_ifu_fq_if.sv - fetch unit bundle: memory request/response, redirect/halt and decode handshake
interface xf100_ifu_fq_if #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int FQ_DEPTH   = 4
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic                  ifu_i_halt;
  logic                  ifu_i_redir_valid;
  logic [PC_SIZE-1:0]    ifu_i_redir_pc;
  logic                  ifu_o_req_valid;
  logic                  ifu_i_req_ready;
  logic [PC_SIZE-1:0]    ifu_o_req_addr;
  logic                  ifu_i_rsp_valid;
  logic [INSTR_SIZE-1:0] ifu_i_rsp_instr;
  logic                  ifu_o_valid;
  logic                  ifu_i_ready;
  logic [INSTR_SIZE-1:0] ifu_o_instr;
  logic [PC_SIZE-1:0]    ifu_o_pc;
  logic [CW-1:0]         ifu_o_fq_cnt;

  modport master (
    input  ifu_i_halt, ifu_i_redir_valid, ifu_i_redir_pc, ifu_i_req_ready,
           ifu_i_rsp_valid, ifu_i_rsp_instr, ifu_i_ready,
    output ifu_o_req_valid, ifu_o_req_addr, ifu_o_valid, ifu_o_instr,
           ifu_o_pc, ifu_o_fq_cnt
  );

  modport slave (
    output ifu_i_halt, ifu_i_redir_valid, ifu_i_redir_pc, ifu_i_req_ready,
           ifu_i_rsp_valid, ifu_i_rsp_instr, ifu_i_ready,
    input  ifu_o_req_valid, ifu_o_req_addr, ifu_o_valid, ifu_o_instr,
           ifu_o_pc, ifu_o_fq_cnt
  );
endinterface

// File: rtl/xf100_ifu_fq.sv
// rtl/xf100_ifu_fq.sv - instruction fetch unit: sequential PC, credit-limited requests, fetch queue
module xf100_ifu_fq #(
  parameter int                  PC_SIZE    = 32,
  parameter int                  INSTR_SIZE = 32,
  parameter int                  FQ_DEPTH   = 4,
  parameter logic [PC_SIZE-1:0]  RESET_PC   = '0
) (
  input logic          clk,
  input logic          rst_n,
  xf100_ifu_fq_if.master bus
);
  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;

  logic [PC_SIZE-1:0]    pc_q;
  logic [PC_SIZE-1:0]    rsp_pc;
  logic [PC_SIZE-1:0]    redir_tgt;
  logic [CW-1:0]         fq_cnt;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [PC_SIZE-1:0]    pc_mem    [FQ_DEPTH];
  logic [INSTR_SIZE-1:0] instr_mem [FQ_DEPTH];

  logic [CW:0] credit_sum;
  logic        credit_ok;
  logic        req_valid;
  logic        req_fire;
  logic        rsp_take;
  logic        rsp_drop;
  logic        push;
  logic        pop;
  logic        fq_valid;
  logic        unused_redir_bits;

  // queue occupancy plus in-flight requests never exceeds the depth, so every response has a slot
  assign credit_sum = {1'b0, fq_cnt} + {1'b0, outstanding};
  assign credit_ok  = credit_sum < (CW+1)'(FQ_DEPTH);
  assign req_valid  = rst_n && !bus.ifu_i_halt && !bus.ifu_i_redir_valid && credit_ok;
  assign req_fire   = req_valid && bus.ifu_i_req_ready;

  assign rsp_take  = bus.ifu_i_rsp_valid && (outstanding != '0);
  assign rsp_drop  = rsp_take && (drop_cnt != '0);
  assign push      = rsp_take && (drop_cnt == '0) && !bus.ifu_i_redir_valid;
  assign fq_valid  = rst_n && (fq_cnt != '0);
  assign pop       = fq_valid && bus.ifu_i_ready && !bus.ifu_i_redir_valid;
  assign redir_tgt = {bus.ifu_i_redir_pc[PC_SIZE-1:2], 2'b00};
  assign unused_redir_bits = ^bus.ifu_i_redir_pc[1:0];

  assign bus.ifu_o_req_valid = req_valid;
  assign bus.ifu_o_req_addr  = pc_q;
  assign bus.ifu_o_valid     = fq_valid;
  assign bus.ifu_o_instr     = fq_valid ? instr_mem[rptr] : '0;
  assign bus.ifu_o_pc        = fq_valid ? pc_mem[rptr] : '0;
  assign bus.ifu_o_fq_cnt    = rst_n ? fq_cnt : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      fq_cnt      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wptr        <= '0;
      rptr        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (bus.ifu_i_redir_valid) begin
        fq_cnt   <= '0;
        wptr     <= '0;
        rptr     <= '0;
        pc_q     <= redir_tgt;
        rsp_pc   <= redir_tgt;
        // every request still in flight after this edge must be discarded on return
        drop_cnt <= outstanding - CW'(rsp_take);
      end else begin
        if (req_fire) pc_q <= pc_q + PC_SIZE'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (push) begin
          wptr   <= wptr + AW'(1);
          rsp_pc <= rsp_pc + PC_SIZE'(4);
        end
        if (pop) rptr <= rptr + AW'(1);
        fq_cnt <= fq_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      pc_mem[wptr]    <= rsp_pc;
      instr_mem[wptr] <= bus.ifu_i_rsp_instr;
    end
  end
endmodule

// File: tb/tb_xf100_ifu_fq.sv
// tb/tb_xf100_ifu_fq.sv - scoreboard bench for the fetch unit with a latency-configurable memory model
module tb_xf100_ifu_fq;
  localparam int          FQ_DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] SCR      = 32'hA5A5_A5A5;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  xf100_ifu_fq_if #(.PC_SIZE(32), .INSTR_SIZE(32), .FQ_DEPTH(FQ_DEPTH)) bus ();

  xf100_ifu_fq #(.PC_SIZE(32), .INSTR_SIZE(32), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;
  int exp_cnt = 0;
  int fire_cnt = 0;
  int first_req_cyc = -1;
  int first_val_cyc = -1;
  int rel_cyc = 0;
  bit stray = 1'b0;
  logic [31:0] exp_pc = RESET_PC;
  mreq_t mq[$];
  sb_t   sb[$];
  logic [31:0] fa[$];
  logic [31:0] dq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory model and scoreboard, evaluated mid-cycle for the upcoming rising edge
  task automatic model();
    int    osd;
    logic  rv, rstale, fire, deq, push, exp_rv;
    mreq_t m;
    sb_t   e;
    if (!rst_n) begin
      chk("rst_valid", bus.ifu_o_valid, 0);
      chk("rst_req_valid", bus.ifu_o_req_valid, 0);
      chk("rst_instr", bus.ifu_o_instr, 0);
      chk("rst_pc", bus.ifu_o_pc, 0);
      chk("rst_cnt", bus.ifu_o_fq_cnt, 0);
      mq.delete();
      sb.delete();
      exp_cnt = 0;
      exp_pc = RESET_PC;
      first_req_cyc = -1;
      first_val_cyc = -1;
      bus.ifu_i_rsp_valid = 1'b0;
    end else begin
      osd = mq.size();
      rv = 1'b0;
      rstale = 1'b0;
      bus.ifu_i_rsp_instr = $urandom;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        m = mq.pop_front();
        rv = 1'b1;
        rstale = m.stale;
        bus.ifu_i_rsp_instr = m.addr ^ SCR;
      end else if (stray && osd == 0) begin
        rv = 1'b1;
        rstale = 1'b1;
      end
      bus.ifu_i_rsp_valid = rv;

      exp_rv = !bus.ifu_i_halt && !bus.ifu_i_redir_valid && (exp_cnt + osd < FQ_DEPTH);
      chk("req_valid", bus.ifu_o_req_valid, exp_rv);
      chk("fq_cnt", bus.ifu_o_fq_cnt, exp_cnt);
      chk("o_valid", bus.ifu_o_valid, exp_cnt != 0);
      if (exp_cnt == 0) chk("empty_zero", {bus.ifu_o_pc, bus.ifu_o_instr}, 0);
      if (bus.ifu_o_req_valid) chk("req_addr", bus.ifu_o_req_addr, exp_pc);

      fire = bus.ifu_o_req_valid && bus.ifu_i_req_ready;
      deq  = bus.ifu_o_valid && bus.ifu_i_ready && !bus.ifu_i_redir_valid;
      push = rv && !rstale && !bus.ifu_i_redir_valid;

      if (fire) begin
        mq.push_back('{addr: bus.ifu_o_req_addr, due: cyc + lat, stale: 1'b0});
        sb.push_back('{pc: bus.ifu_o_req_addr, instr: bus.ifu_o_req_addr ^ SCR});
        fa.push_back(bus.ifu_o_req_addr);
        fire_cnt++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (bus.ifu_o_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (deq) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("deq_pc", bus.ifu_o_pc, e.pc);
          chk("deq_instr", bus.ifu_o_instr, e.instr);
        end
        dq.push_back(bus.ifu_o_pc);
      end

      if (bus.ifu_i_redir_valid) begin
        exp_cnt = 0;
        sb.delete();
        foreach (mq[i]) mq[i].stale = 1'b1;
        exp_pc = bus.ifu_i_redir_pc & 32'hFFFF_FFFC;
      end else begin
        exp_cnt = exp_cnt + int'(push) - int'(deq);
        if (fire) exp_pc = exp_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fires(input int n, input int budget);
    int k = 0;
    while (fire_cnt < n && k < budget) begin step(); k++; end
    chk("wait_fires", fire_cnt >= n, 1);
  endtask

  task automatic wait_deq(input int n, input int budget);
    int k = 0;
    while (dq.size() < n && k < budget) begin step(); k++; end
    chk("wait_deq", dq.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(exp_cnt == 0 && mq.size() == 0) && k < budget) begin step(); k++; end
    chk("wait_idle", exp_cnt == 0 && mq.size() == 0, 1);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus.ifu_i_redir_valid = 1'b1;
    bus.ifu_i_redir_pc = tgt;
    step();
    bus.ifu_i_redir_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ifu_i_halt = 1'b0;
    bus.ifu_i_redir_valid = 1'b0;
    bus.ifu_i_redir_pc = '0;
    bus.ifu_i_req_ready = 1'b1;
    bus.ifu_i_ready = 1'b1;
    bus.ifu_i_rsp_valid = 1'b0;
    bus.ifu_i_rsp_instr = '0;
    repeat (3) step();

    // streaming from reset, latency 1
    rel_cyc = cyc;
    rst_n = 1'b1;
    wait_deq(6, 40);
    chk("first_req_cyc", first_req_cyc, rel_cyc);
    chk("first_valid_lat", first_val_cyc - first_req_cyc, 2);
    chk("first_pc", dq[0], 32'h0);
    chk("second_pc", dq[1], 32'h4);

    // decode stall fills exactly the queue depth
    bus.ifu_i_halt = 1'b1;
    wait_idle(40);
    fire_cnt = 0;
    bus.ifu_i_ready = 1'b0;
    bus.ifu_i_halt = 1'b0;
    repeat (10) step();
    chk("stall_fires", fire_cnt, 4);
    chk("stall_req_valid", bus.ifu_o_req_valid, 0);
    chk("stall_cnt", bus.ifu_o_fq_cnt, 4);
    dq.delete();
    bus.ifu_i_ready = 1'b1;
    wait_deq(4, 20);
    repeat (3) step();
    chk("stall_resume", fire_cnt > 4, 1);

    // redirect with three in flight at latency 3
    bus.ifu_i_halt = 1'b1;
    wait_idle(40);
    redirect(32'h10);
    lat = 3;
    fire_cnt = 0;
    bus.ifu_i_halt = 1'b0;
    wait_fires(3, 20);
    redirect(32'h103);
    chk("redir_flush_cnt", bus.ifu_o_fq_cnt, 0);
    fa.delete();
    dq.delete();
    wait_deq(1, 30);
    chk("redir_first_req", fa[0], 32'h100);
    chk("redir_first_pc", dq[0], 32'h100);

    // redirect colliding with a response and a dequeue
    lat = 1;
    repeat (6) step();
    chk("collide_head_valid", bus.ifu_o_valid, 1);
    redirect(32'h200);
    dq.delete();
    wait_deq(4, 30);
    chk("collide_first_pc", dq[0], 32'h200);

    // stray response with nothing outstanding, then halt with two in flight
    bus.ifu_i_halt = 1'b1;
    wait_idle(40);
    stray = 1'b1;
    repeat (2) step();
    stray = 1'b0;
    redirect(32'h300);
    lat = 3;
    fire_cnt = 0;
    bus.ifu_i_halt = 1'b0;
    wait_fires(2, 20);
    bus.ifu_i_halt = 1'b1;
    bus.ifu_i_ready = 1'b0;
    fire_cnt = 0;
    repeat (8) step();
    chk("halt_fires", fire_cnt, 0);
    chk("halt_cnt", bus.ifu_o_fq_cnt, 2);
    fa.delete();
    bus.ifu_i_halt = 1'b0;
    bus.ifu_i_ready = 1'b1;
    wait_fires(1, 20);
    chk("halt_resume_addr", fa[0], 32'h308);

    // address wrap, then reset mid-stream
    lat = 1;
    redirect(32'hFFFF_FFFC);
    fa.delete();
    fire_cnt = 0;
    wait_fires(2, 30);
    chk("wrap_addr0", fa[0], 32'hFFFF_FFFC);
    chk("wrap_addr1", fa[1], 32'h0000_0000);
    repeat (3) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", bus.ifu_o_valid, 0);
    chk("mid_rst_cnt", bus.ifu_o_fq_cnt, 0);
    chk("mid_rst_addr", bus.ifu_o_req_addr, RESET_PC);
    step();
    rst_n = 1'b1;
    fa.delete();
    dq.delete();
    fire_cnt = 0;
    wait_fires(2, 20);
    wait_deq(2, 20);
    chk("post_rst_addr0", fa[0], RESET_PC);
    chk("post_rst_addr1", fa[1], RESET_PC + 32'd4);
    chk("post_rst_pc0", dq[0], RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/xf100_ifu_fq.md
Name: xf100_ifu_fq

Overview:
- Parametrised instruction fetch unit with a fetch queue.
- Generates sequential PCs and issues pipelined, in-order requests to instruction memory with a credit limit.
- Buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/exception flush), halt, and discard of stale in-flight responses. Sits between the instruction memory port and decode inside the core top.

Parameters:
- PC_SIZE, 32, width of PC and memory address.
- INSTR_SIZE, 32, instruction width.
- FQ_DEPTH, 4, fetch queue entries; also the maximum outstanding requests (power of two, at least 2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ifu_i_halt  in  1  when 1, no new memory requests are issued; the queue still drains.
- ifu_i_redir_valid  in  1  redirect/flush request.
- ifu_i_redir_pc  in  PC_SIZE  redirect target; bits [1:0] are ignored and treated as 0.
- ifu_o_req_valid  out  1  memory request valid.
- ifu_i_req_ready  in  1  memory accepts the request.
- ifu_o_req_addr  out  PC_SIZE  request address, equal to pc_q.
- ifu_i_rsp_valid  in  1  memory response; in order, latency at least 1, no backpressure.
- ifu_i_rsp_instr  in  INSTR_SIZE  response data.
- ifu_o_valid  out  1  head-of-queue instruction valid to decode.
- ifu_i_ready  in  1  decode accepts.
- ifu_o_instr  out  INSTR_SIZE  head instruction; 0 when the queue is empty.
- ifu_o_pc  out  PC_SIZE  PC of the head instruction; 0 when the queue is empty.
- ifu_o_fq_cnt  out  $clog2(FQ_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (synchronous, rst_n==0 at the edge): pc_q=RESET_PC; rsp_pc=RESET_PC; fq_cnt, outstanding and drop_cnt =0; read/write pointers =0.
- Outputs while in reset: ifu_o_valid=0, ifu_o_req_valid=0, ifu_o_instr=0, ifu_o_pc=0, ifu_o_fq_cnt=0.
- Reset asserted mid-operation discards everything. Memory is reset in the same cycle; no response is expected afterwards.
- Credit: ifu_o_req_valid = !ifu_i_halt && !ifu_i_redir_valid && (fq_cnt + outstanding < FQ_DEPTH). Every accepted request is therefore guaranteed a queue slot.
- Request handshake (req_valid && req_ready): pc_q += 4, wrapping modulo 2^PC_SIZE; outstanding += 1. If req_valid is 1 and req_ready is 0, the address must stay stable and req_valid stays asserted unless halt or redirect rises.
- Response with drop_cnt>0: the data is discarded, drop_cnt -= 1, outstanding -= 1.
- Response with drop_cnt==0: write {rsp_pc, rsp_instr} at the write pointer; rsp_pc += 4; outstanding -= 1.
- A response arriving with outstanding==0 is ignored and changes no state.
- Same-cycle request and response: outstanding is unchanged.
- Dequeue: ifu_o_valid = (fq_cnt != 0). On valid && ready the read pointer advances and fq_cnt -= 1. Same-cycle push and pop leave fq_cnt unchanged.
- Full queue: no push can occur because of the credit rule.
- Latency: response in cycle N gives ifu_o_valid in cycle N+1; there is no bypass.
- Reset release: first req_valid in the first cycle with rst_n==1 and halt==0.
- Redirect (ifu_i_redir_valid==1 at the edge), which has priority over all other updates:
  - queue flushed: fq_cnt=0, pointers =0;
  - pc_q = rsp_pc = {redir_pc[PC_SIZE-1:2], 2'b00};
  - drop_cnt = outstanding minus 1 if a response arrives this cycle, else outstanding (i.e. drop_cnt + pending responses accounts for every in-flight request);
  - outstanding is updated by the response normally;
  - a same-cycle response and a same-cycle dequeue are discarded;
  - no request is issued that cycle.
- Back-to-back redirects: each one recomputes drop_cnt from the current outstanding count.
- Halt: suppresses requests only. Outstanding responses still fill the queue; redirect still applies during halt.
- Queue storage: register array, no reset required on data; output muxing forces 0 when empty.

Test Plan:
- Reset, then rst_n=1, req_ready=1, memory latency 1 returning instr=addr^32'hA5A5_A5A5, decode ready=1:
  - requests are issued to 0x0, 0x4, 0x8, …;
  - ifu_o_pc sequence 0x0, 0x4, … with matching instr;
  - ifu_o_valid first high 2 cycles after the first request.
- Decode ready=0, memory always ready, FQ_DEPTH=4: exactly 4 requests are issued, then req_valid=0 and fq_cnt=4. Raising ready drains 4 entries in order and requests resume one per freed slot.
- Latency-3 memory with 3 outstanding at 0x10/0x14/0x18, redirect to 0x103:
  - the 3 responses are dropped;
  - next request address 0x100;
  - first delivered ifu_o_pc=0x100;
  - fq_cnt=0 in the cycle after the redirect.
- Redirect in the same cycle as a response and a dequeue: the response is dropped, the head is not consumed, drop_cnt = outstanding-1.
- Halt=1 with 2 outstanding: no new requests are issued, the 2 responses enqueue, req_valid stays 0 until halt=0, then fetching resumes at the next sequential PC.
- PC_SIZE=32, redirect to 0xFFFF_FFFC: requests go to 0xFFFF_FFFC then 0x0000_0000 (wrap). Asserting rst_n=0 mid-stream clears valid, count and PC to RESET_PC on the next edge.
